// File: rtl/ifetch_ctrl.sv
// Instruction-fetch front end: owns the fetch PC, runs the single-outstanding
// instruction bus handshake, and buffers up to two {pc, inst} entries for decode.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        adv_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        ireq_valid_o,
  output logic [63:0] ireq_addr_o,
  input  logic        iresp_addr_ok_i,
  input  logic        iresp_data_ok_i,
  input  logic [31:0] iresp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP_REQ,
    S_DROP_WAIT
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  entry_t      fifo_q [2];
  logic [1:0]  count_q;

  logic        pop;
  logic        resp_ok;
  logic        push;
  logic [1:0]  count_next;
  logic        space;
  logic        issue;
  logic        wr_slot0;
  logic [63:0] redirect_target;
  logic        unused_pc_bits;

  assign redirect_target = {redirect_pc_i[63:2], 2'b00};
  assign unused_pc_bits  = &redirect_pc_i[1:0];

  // A response is only real once the address phase has been accepted.
  assign resp_ok = ((state_q == S_REQ) && iresp_addr_ok_i && iresp_data_ok_i) ||
                   ((state_q == S_WAIT) && iresp_data_ok_i);
  assign push       = resp_ok && !redirect_i;
  assign pop        = adv_i && (count_q != 2'd0);
  assign count_next = count_q + {1'b0, push} - {1'b0, pop};
  assign space      = (count_next <= 2'd1);
  assign wr_slot0   = (count_q == 2'd0) || ((count_q == 2'd1) && pop);

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    issue      = 1'b0;

    if (redirect_i) begin
      pc_d = redirect_target;
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_REQ: begin
          if (iresp_addr_ok_i && iresp_data_ok_i) state_d = S_IDLE;
          else if (iresp_addr_ok_i)               state_d = S_DROP_WAIT;
          else                                    state_d = S_DROP_REQ;
        end
        S_WAIT:  state_d = iresp_data_ok_i ? S_IDLE : S_DROP_WAIT;
        default: state_d = state_q;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: issue = space;
        S_REQ: begin
          if (iresp_addr_ok_i && iresp_data_ok_i) begin
            if (space) issue   = 1'b1;
            else       state_d = S_IDLE;
          end else if (iresp_addr_ok_i) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (iresp_data_ok_i) begin
            if (space) issue   = 1'b1;
            else       state_d = S_IDLE;
          end
        end
        S_DROP_REQ: begin
          if (iresp_addr_ok_i && iresp_data_ok_i) state_d = S_IDLE;
          else if (iresp_addr_ok_i)               state_d = S_DROP_WAIT;
        end
        S_DROP_WAIT: begin
          if (iresp_data_ok_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (issue) begin
      state_d    = S_REQ;
      req_addr_d = pc_q;
      pc_d       = pc_q + 64'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // NOTE: the two FIFO entries are reset because the head is visible on the
  // outputs; a deep storage array would normally be left unreset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (redirect_i) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_next;
      if (pop) fifo_q[0] <= fifo_q[1];
      if (push) begin
        if (wr_slot0) fifo_q[0] <= '{pc: req_addr_q, inst: iresp_data_i};
        else          fifo_q[1] <= '{pc: req_addr_q, inst: iresp_data_i};
      end
    end
  end

  assign ireq_valid_o = (state_q == S_REQ) || (state_q == S_DROP_REQ);
  assign ireq_addr_o  = req_addr_q;
  assign inst_valid_o = (count_q != 2'd0);
  assign inst_o       = inst_valid_o ? fifo_q[0].inst : 32'd0;
  assign inst_pc_o    = inst_valid_o ? fifo_q[0].pc   : 64'd0;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: per-cycle vector table plus a hand-written
// asynchronous-reset-during-WAIT sequence.
module tb_ifetch_ctrl;

  localparam logic [63:0] B = 64'h8000_0000;
  localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        adv_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        ireq_valid_o;
  logic [63:0] ireq_addr_o;
  logic        iresp_addr_ok_i = 1'b0;
  logic        iresp_data_ok_i = 1'b0;
  logic [31:0] iresp_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;

  int tests = 0;
  int fails = 0;

  ifetch_ctrl #(.RESET_PC(B)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .adv_i           (adv_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .ireq_valid_o    (ireq_valid_o),
    .ireq_addr_o     (ireq_addr_o),
    .iresp_addr_ok_i (iresp_addr_ok_i),
    .iresp_data_ok_i (iresp_data_ok_i),
    .iresp_data_i    (iresp_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o)
  );

  always #5 clk = ~clk;

  // Bench memory: the word stored at an address is tagged with its low bits.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  typedef struct {
    bit          rst;
    logic        adv;
    logic        redir;
    logic [63:0] rpc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_rv;
    logic [63:0] e_ra;
    logic        e_iv;
    logic [63:0] e_ipc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input logic adv, input logic redir,
                              input logic [63:0] rpc, input logic aok, input logic dok,
                              input logic [63:0] dat_a, input logic e_rv,
                              input logic [63:0] e_ra, input logic e_iv,
                              input logic [63:0] e_ipc);
    vec_t v;
    v.rst = rst;   v.adv = adv;   v.redir = redir; v.rpc = rpc;
    v.aok = aok;   v.dok = dok;   v.rdata = mem_word(dat_a);
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv;   v.e_ipc = e_ipc;
    v.e_inst = e_iv ? mem_word(e_ipc) : 32'd0;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic e_rv, input logic [63:0] e_ra,
                       input logic e_iv, input logic [63:0] e_ipc, input logic [31:0] e_inst);
    tests++;
    if (ireq_valid_o !== e_rv || ireq_addr_o !== e_ra || inst_valid_o !== e_iv ||
        inst_pc_o !== e_ipc || inst_o !== e_inst) begin
      fails++;
      $display("FAIL %s: got rv=%0b ra=%h iv=%0b ipc=%h inst=%h, want rv=%0b ra=%h iv=%0b ipc=%h inst=%h",
               name, ireq_valid_o, ireq_addr_o, inst_valid_o, inst_pc_o, inst_o,
               e_rv, e_ra, e_iv, e_ipc, e_inst);
    end
  endtask

  task automatic drive(input logic adv, input logic redir, input logic [63:0] rpc,
                       input logic aok, input logic dok, input logic [31:0] rdata);
    adv_i = adv; redirect_i = redir; redirect_pc_i = rpc;
    iresp_addr_ok_i = aok; iresp_data_ok_i = dok; iresp_data_i = rdata;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0);
    resetn = 1'b0;
    #1 check("reset", 1'b0, B, 1'b0, 64'd0, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // A push into a full FIFO must never be attempted.
  always @(posedge clk) begin
    if (resetn && dut.push && dut.count_q == 2'd2) begin
      fails++;
      $display("FAIL push_full: push with count=%0d, want count<2", dut.count_q);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst adv redir rpc  aok dok dat_a | rv ra  iv ipc
    // Start-up, bus always ready, adv=1.
    add(1, 1, 0, 0, 1, 1, B,      0, B,      0, 0);
    add(0, 1, 0, 0, 1, 1, B,      1, B,      0, 0);
    add(0, 1, 0, 0, 1, 1, B + 4,  1, B + 4,  1, B);
    add(0, 1, 0, 0, 1, 1, B + 8,  1, B + 8,  1, B + 4);
    add(0, 1, 0, 0, 1, 1, B + 12, 1, B + 12, 1, B + 8);
    // Back-pressure: two entries fill, request stops, resumes at +8.
    add(1, 0, 0, 0, 1, 1, B,      0, B,      0, 0);
    add(0, 0, 0, 0, 1, 1, B,      1, B,      0, 0);
    add(0, 0, 0, 0, 1, 1, B + 4,  1, B + 4,  1, B);
    add(0, 0, 0, 0, 1, 1, B + 8,  0, B + 4,  1, B);
    add(0, 1, 0, 0, 1, 1, B + 8,  0, B + 4,  1, B);
    add(0, 1, 0, 0, 1, 1, B + 8,  1, B + 8,  1, B + 4);
    add(0, 1, 0, 0, 1, 1, B + 12, 1, B + 12, 1, B + 8);
    // Redirect while waiting for data of +4.
    add(1, 0, 0, 0,          1, 1, B,         0, B,         0, 0);
    add(0, 0, 0, 0,          1, 1, B,         1, B,         0, 0);
    add(0, 0, 0, 0,          1, 0, B,         1, B + 4,     1, B);
    add(0, 0, 0, 0,          0, 0, B,         0, B + 4,     1, B);
    add(0, 0, 1, B + 'h100,  0, 0, B,         0, B + 4,     1, B);
    add(0, 0, 0, 0,          0, 1, B + 4,     0, B + 4,     0, 0);
    add(0, 0, 0, 0,          0, 0, B,         0, B + 4,     0, 0);
    add(0, 0, 0, 0,          1, 1, B + 'h100, 1, B + 'h100, 0, 0);
    add(0, 0, 0, 0,          0, 0, B,         1, B + 'h104, 1, B + 'h100);
    // Redirect before the request is accepted.
    add(1, 0, 0, 0,          0, 0, B,         0, B,         0, 0);
    add(0, 0, 0, 0,          0, 0, B,         1, B,         0, 0);
    add(0, 0, 1, B + 'h200,  0, 0, B,         1, B,         0, 0);
    add(0, 0, 0, 0,          0, 0, B,         1, B,         0, 0);
    add(0, 0, 0, 0,          1, 0, B,         1, B,         0, 0);
    add(0, 0, 0, 0,          0, 1, B,         0, B,         0, 0);
    add(0, 0, 0, 0,          0, 0, B,         0, B,         0, 0);
    add(0, 0, 0, 0,          1, 1, B + 'h200, 1, B + 'h200, 0, 0);
    add(0, 0, 0, 0,          0, 0, B,         1, B + 'h204, 1, B + 'h200);
    // Redirect + adv + data_ok together, misaligned target.
    add(1, 0, 0, 0,          1, 1, B,         0, B,         0, 0);
    add(0, 0, 0, 0,          1, 1, B,         1, B,         0, 0);
    add(0, 1, 1, B + 'h203,  1, 1, B + 4,     1, B + 4,     1, B);
    add(0, 0, 0, 0,          0, 0, B,         0, B + 4,     0, 0);
    add(0, 0, 0, 0,          1, 1, B + 'h200, 1, B + 'h200, 0, 0);
    add(0, 0, 0, 0,          0, 0, B,         1, B + 'h204, 1, B + 'h200);
    // Redirect from IDLE near the top of the address space; PC wraps to 0.
    add(1, 0, 1, W,          0, 0, B,         0, B,         0, 0);
    add(0, 1, 0, 0,          0, 0, B,         0, B,         0, 0);
    add(0, 1, 0, 0,          1, 1, W,         1, W,         0, 0);
    add(0, 1, 0, 0,          1, 1, W + 4,     1, W + 4,     1, W);
    add(0, 1, 0, 0,          1, 1, 64'd0,     1, 64'd0,     1, W + 4);
    add(0, 1, 0, 0,          0, 0, 64'd0,     1, 64'd4,     1, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      else             @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_ra, vecs[i].e_iv,
            vecs[i].e_ipc, vecs[i].e_inst);
      drive(vecs[i].adv, vecs[i].redir, vecs[i].rpc, vecs[i].aok, vecs[i].dok,
            vecs[i].rdata);
    end

    // Asynchronous reset while a request waits for data.
    do_reset();
    drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, mem_word(B));
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, mem_word(B));
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("wait_state", 1'b0, B + 4, 1'b1, B, mem_word(B));
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0);
    #2 resetn = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, mem_word(B + 4));
    #1 check("async_reset", 1'b0, B, 1'b0, 64'd0, 32'd0);
    @(negedge clk);
    check("reset_hold", 1'b0, B, 1'b0, 64'd0, 32'd0);
    resetn = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, mem_word(B));
    @(negedge clk);
    check("restart_req", 1'b1, B, 1'b0, 64'd0, 32'd0);
    @(negedge clk);
    check("restart_data", 1'b1, B + 4, 1'b1, B, mem_word(B));
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
